// File: rtl/bcd_adder8_pkg.sv
// Shared definitions for the 8-bit BCD adder: display select codes,
// controller state encoding and BCD digit limits.
package bcd_adder8_pkg;

  // Display mux select codes (also used by the downstream output mux)
  localparam logic [2:0] SHOWA     = 3'd0;
  localparam logic [2:0] SHOWB     = 3'd1;
  localparam logic [2:0] SHOWCIN   = 3'd2;
  localparam logic [2:0] SHOWRSLT  = 3'd3;
  localparam logic [2:0] SHOWBLNKS = 3'd5;
  localparam logic [2:0] SHOWERR   = 3'd6;

  // Largest legal BCD digit
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_ENTER_A   = 3'd0,
    ST_ENTER_B   = 3'd1,
    ST_ENTER_CIN = 3'd2,
    ST_ADD_LO    = 3'd3,
    ST_ADD_HI    = 3'd4,
    ST_SHOW_RSLT = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  // True when both nibbles of a byte are legal BCD digits
  function automatic logic bcd_byte_ok(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: a + b + cin with decimal correction.
module bcd_digit_add
  import bcd_adder8_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [4:0] sum;

  // Binary sum then +6 correction when it exceeds one decimal digit
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    if (sum > {1'b0, BCD_MAX}) begin
      digit_o = sum[3:0] + 4'd6;
      cout_o  = 1'b1;
    end else begin
      digit_o = sum[3:0];
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_adder8_ctl.sv
// Operand entry sequencer and two-digit BCD add for the DE1 display path.
// One digit adder is time-shared: ones digit in ADD_LO, tens in ADD_HI.
module bcd_adder8_ctl
  import bcd_adder8_pkg::*;
#(
  parameter int BLINK_CNT = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic [9:0]  SW,
  output logic [11:0] RSLT,
  output logic [2:0]  out_mux_sel
);

  localparam int CW = $clog2(BLINK_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CNT - 1);

  state_e        state_q, state_d;
  logic          btn_q;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic          cin_q, cin_d;
  logic          c1_q, c1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [11:0]   rslt_q, rslt_d;

  logic          press;
  logic          sw_ok;
  logic [3:0]    add_a, add_b, add_digit;
  logic          add_cin, add_cout;
  logic          unused_sw;

  assign press     = btn & ~btn_q;
  assign sw_ok     = bcd_byte_ok(SW[7:0]);
  assign unused_sw = ^SW[9:8];
  assign RSLT      = rslt_q;

  // Operand mux: tens digits and tens carry in ADD_HI, ones digits otherwise
  always_comb begin
    if (state_q == ST_ADD_HI) begin
      add_a   = a_q[7:4];
      add_b   = b_q[7:4];
      add_cin = c1_q;
    end else begin
      add_a   = a_q[3:0];
      add_b   = b_q[3:0];
      add_cin = cin_q;
    end
  end

  bcd_digit_add u_digit (
    .a_i     (add_a),
    .b_i     (add_b),
    .cin_i   (add_cin),
    .digit_o (add_digit),
    .cout_o  (add_cout)
  );

  // Button edge register; resets high so a held button is not a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_q <= 1'b1;
    else       btn_q <= btn;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ENTER_A;
    else       state_q <= state_d;
  end

  // Next-state logic; one transition per press, add states run unconditionally
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ENTER_A: begin
        if (press) state_d = sw_ok ? ST_ENTER_B : ST_ERR;
        else       state_d = ST_ENTER_A;
      end
      ST_ENTER_B: begin
        if (press) state_d = sw_ok ? ST_ENTER_CIN : ST_ERR;
        else       state_d = ST_ENTER_B;
      end
      ST_ENTER_CIN: begin
        if (press) state_d = ST_ADD_LO;
        else       state_d = ST_ENTER_CIN;
      end
      ST_ADD_LO:    state_d = ST_ADD_HI;
      ST_ADD_HI:    state_d = ST_SHOW_RSLT;
      ST_SHOW_RSLT: begin
        if (press) state_d = ST_ENTER_A;
        else       state_d = ST_SHOW_RSLT;
      end
      ST_ERR: begin
        if (press) state_d = ST_ENTER_A;
        else       state_d = ST_ERR;
      end
      default:      state_d = ST_ENTER_A;
    endcase
  end

  // Display select decode from state and blink phase
  always_comb begin
    out_mux_sel = SHOWA;
    unique case (state_q)
      ST_ENTER_A:   out_mux_sel = SHOWA;
      ST_ENTER_B:   out_mux_sel = SHOWB;
      ST_ENTER_CIN: out_mux_sel = SHOWCIN;
      ST_ADD_LO:    out_mux_sel = SHOWBLNKS;
      ST_ADD_HI:    out_mux_sel = SHOWBLNKS;
      ST_SHOW_RSLT: out_mux_sel = SHOWRSLT;
      ST_ERR: begin
        if (phase_q) out_mux_sel = SHOWBLNKS;
        else         out_mux_sel = SHOWERR;
      end
      default:      out_mux_sel = SHOWA;
    endcase
  end

  // Datapath next values: operand capture, add results, blink timing
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    c1_d    = c1_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rslt_d  = rslt_q;
    unique case (state_q)
      ST_ENTER_A: begin
        if (press && sw_ok) a_d = SW[7:0];
        else                a_d = a_q;
      end
      ST_ENTER_B: begin
        if (press && sw_ok) b_d = SW[7:0];
        else                b_d = b_q;
      end
      ST_ENTER_CIN: begin
        if (press) cin_d = SW[0];
        else       cin_d = cin_q;
      end
      ST_ADD_LO: begin
        rslt_d = {rslt_q[11:4], add_digit};
        c1_d   = add_cout;
      end
      ST_ADD_HI: begin
        rslt_d = {3'b000, add_cout, add_digit, rslt_q[3:0]};
      end
      ST_SHOW_RSLT: begin
        rslt_d = rslt_q;
      end
      ST_ERR: begin
        if (press) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          phase_d = phase_q;
        end
      end
      default: begin
        rslt_d = rslt_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 1'b0;
      c1_q    <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rslt_q  <= 12'h000;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      c1_q    <= c1_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rslt_q  <= rslt_d;
    end
  end

endmodule

// File: doc/bcd_adder8_ctl.md
# bcd_adder8_ctl

Control and datapath stage for the 8-bit BCD adder on the DE1. It sits directly upstream of the display output mux. It sequences operand entry (A, B, carry-in) from the slide switches under a debounced pushbutton, and validates each BCD operand. It performs the two-digit BCD add and drives the mux select code and the 12-bit result register that the mux consumes.

## Interface
- `BLINK_CNT`, default 25_000_000: clock cycles per half-period of the error blink (0.5 s at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `btn` in 1: debounced, synchronous, active-high "next" pushbutton level.
- `SW` in 10: slide switches; SW[7:0] operand digits, SW[0] carry-in.
- `RSLT` out 12: result register {3'b000, hundreds bit, tens digit, ones digit}.
- `out_mux_sel` out 3: display select; 0=SHOWA, 1=SHOWB, 2=SHOWCIN, 3=SHOWRSLT, 5=SHOWBLNKS, 6=SHOWERR.

## Operation
- Press = `btn`=1 while registered `btn_q`=0. `btn_q` resets to 1, so a button held through reset produces no press until it is released and pressed again.
- Registers: A[7:0], B[7:0], CIN, tens carry C1, state, blink counter, blink phase, RSLT. All reset to 0, except `btn_q`=1 and state=ENTER_A.
- States and `out_mux_sel` decode (combinational from state and blink phase):
  - ENTER_A (sel 0): on press, if SW[7:4]≤9 and SW[3:0]≤9, capture A←SW[7:0] and go to ENTER_B; otherwise go to ERR.
  - ENTER_B (sel 1): same check; capture B and go to ENTER_CIN, or go to ERR.
  - ENTER_CIN (sel 2): on press, CIN←SW[0] and go to ADD_LO. There is no validation.
  - ADD_LO (sel 5): RSLT[3:0]←ones digit of A[3:0]+B[3:0]+CIN; C1←carry. Always go to ADD_HI.
  - ADD_HI (sel 5): RSLT[7:4]←tens digit of A[7:4]+B[7:4]+C1; RSLT[8]←carry; RSLT[11:9]←0. Go to SHOW_RSLT.
  - SHOW_RSLT (sel 3): hold RSLT; on press go to ENTER_A.
  - ERR: sel is 6 when blink phase=0 and 5 when phase=1. The counter increments each cycle; at BLINK_CNT-1 it wraps to 0 and toggles the phase. On press, go to ENTER_A and clear the counter and phase. A and B keep their prior values.
- Digit add: s = a+b+cin (5 bits, max 19). If s>9, digit=s+6 truncated to 4 bits and carry=1; otherwise digit=s and carry=0.
- An invalid B also goes to ERR. Recovery always restarts at ENTER_A.
- Presses in ADD_LO and ADD_HI are ignored (consumed, no effect).
- RSLT changes only in ADD_LO and ADD_HI. It is otherwise stable, including across ERR and new operand entry.

## Timing
- Press sampled at edge n on ENTER_CIN: state=ADD_LO after n, ADD_HI after n+1, SHOW_RSLT after n+2. RSLT is final and sel=3 from edge n+2, so latency is 3 edges from press to valid display.
- RSLT[3:0] updates one edge before RSLT[8:4]. The display is blanked (sel 5) during this window.
- Exactly one state transition per press. A press held for many cycles counts once.
- Reset asserted at any time, including mid-add or mid-blink: on assertion, sel=0, RSLT=0, counter=0. The first transition requires a fresh press after reset deassert.
- ERR first shows sel 6 for BLINK_CNT cycles, then sel 5 for BLINK_CNT cycles, repeating.

## Structure
- Shared package `bcd_adder8_pkg`: out_mux_sel codes (SHOWA..SHOWERR), state encoding, BCD digit maximum (9). The output mux includes the same select codes.
- One sub-module `bcd_digit_add`: combinational, 4-bit a, 4-bit b, 1-bit cin → 4-bit digit, cout. Instantiated once and shared between ADD_LO and ADD_HI via operand muxing.
- Blink counter width is $clog2(BLINK_CNT).

## Test plan
- Reset with `btn` held high, then release and hold 10 cycles: sel=0, RSLT=0x000, no transition. The first fresh press with SW=0x12 moves to sel=1.
- A=0x45, B=0x38, CIN=1: RSLT=0x084, sel=3 exactly 3 edges after the CIN press. Sel=5 on the two intervening cycles.
- A=0x99, B=0x99, CIN=1: RSLT=0x199. A=0x00, B=0x00, CIN=0: RSLT=0x000.
- BLINK_CNT=4, SW=0x4A pressed in ENTER_A: sel=6 for 4 cycles, then 5 for 4, then 6. A press returns sel=0 and prior RSLT is unchanged.
- Valid A, then B with SW=0xA1: ERR. A press returns to ENTER_A, not ENTER_B.
- Reset asserted during ADD_HI (or mid-ERR): sel=0 and RSLT=0x000 asynchronously. A single press held 20 cycles advances exactly one state.
